// File: rtl/tanh_vector_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tanh_vector_sequencer: streams FP32 pairs through float_tanh_dual  |
// | and writes the paired results back in issue order. Rev 1.0         |
// +--------------------------------------------------------------------+
module tanh_vector_sequencer #(
  parameter  int VEC_LEN = 32,
  localparam int NPAIR   = VEC_LEN / 2,
  localparam int PW      = $clog2(NPAIR + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [PW-1:0] len_pairs,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [PW-1:0] rd_addr,
  input  logic [31:0]   rd_data1,
  input  logic [31:0]   rd_data2,
  output logic [31:0]   tanh_din1,
  output logic [31:0]   tanh_din2,
  output logic          tanh_valid,
  input  logic          tanh_ready,
  input  logic          tanh_done,
  input  logic [31:0]   tanh_dout1,
  input  logic [31:0]   tanh_dout2,
  output logic          res_wr_en,
  output logic [PW-1:0] res_wr_addr,
  output logic [31:0]   res_wr_data1,
  output logic [31:0]   res_wr_data2
);

  localparam logic [PW-1:0] NPAIR_W = PW'(NPAIR);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_ISSUE  = 3'd2,
    S_DRAIN  = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] len_q, len_d;
  logic [PW-1:0] iss_idx_q, iss_idx_d;
  logic [PW-1:0] wr_idx_q, wr_idx_d;
  logic [PW-1:0] inflight_q, inflight_d;
  logic [31:0]   din1_q, din1_d;
  logic [31:0]   din2_q, din2_d;
  logic          err_q, err_d;
  logic          wr_en_q, wr_en_d;
  logic [PW-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]   wr_data1_q, wr_data1_d;
  logic [31:0]   wr_data2_q, wr_data2_d;

  logic          issue_xfer;
  logic          collect;
  logic [PW-1:0] len_in;

  assign issue_xfer = (state_q == S_ISSUE) && tanh_ready;
  // A result is only legitimate when something is outstanding in the unit.
  assign collect    = tanh_done && (state_q != S_IDLE) && (inflight_q != '0);
  assign len_in     = (len_pairs > NPAIR_W) ? NPAIR_W : len_pairs;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    iss_idx_d  = iss_idx_q;
    wr_idx_d   = wr_idx_q;
    inflight_d = inflight_q;
    din1_d     = din1_q;
    din2_d     = din2_q;
    err_d      = err_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data1_d = wr_data1_q;
    wr_data2_d = wr_data2_q;

    if (tanh_done) begin
      if (collect) begin
        wr_en_d    = 1'b1;
        wr_addr_d  = wr_idx_q;
        wr_data1_d = tanh_dout1;
        wr_data2_d = tanh_dout2;
        wr_idx_d   = wr_idx_q + 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end

    if (issue_xfer && !collect) begin
      inflight_d = inflight_q + 1'b1;
    end else if (!issue_xfer && collect) begin
      inflight_d = inflight_q - 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d      = len_in;
          iss_idx_d  = '0;
          wr_idx_d   = '0;
          inflight_d = '0;
          state_d    = (len_in == '0) ? S_FINISH : S_FETCH;
        end
      end
      S_FETCH: begin
        din1_d  = rd_data1;
        din2_d  = rd_data2;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (tanh_ready) begin
          iss_idx_d = iss_idx_q + 1'b1;
          state_d   = (iss_idx_d == len_q) ? S_DRAIN : S_FETCH;
        end
      end
      S_DRAIN: begin
        if (wr_idx_q == len_q) begin
          state_d = S_FINISH;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      iss_idx_q  <= '0;
      wr_idx_q   <= '0;
      inflight_q <= '0;
      din1_q     <= '0;
      din2_q     <= '0;
      err_q      <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data1_q <= '0;
      wr_data2_q <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      iss_idx_q  <= iss_idx_d;
      wr_idx_q   <= wr_idx_d;
      inflight_q <= inflight_d;
      din1_q     <= din1_d;
      din2_q     <= din2_d;
      err_q      <= err_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data1_q <= wr_data1_d;
      wr_data2_q <= wr_data2_d;
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_FINISH);
  assign err          = err_q;
  assign rd_addr      = (state_q == S_FETCH) ? iss_idx_q : '0;
  assign tanh_valid   = (state_q == S_ISSUE);
  assign tanh_din1    = din1_q;
  assign tanh_din2    = din2_q;
  assign res_wr_en    = wr_en_q;
  assign res_wr_addr  = wr_addr_q;
  assign res_wr_data1 = wr_data1_q;
  assign res_wr_data2 = wr_data2_q;

endmodule
`default_nettype wire

// File: tb/tb_tanh_vector_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_tanh_vector_sequencer: random vectors through a latency model   |
// | of float_tanh_dual, checked against an in-order result list. Rev 1.0|
// +--------------------------------------------------------------------+
module tb_tanh_vector_sequencer;
  localparam int VEC_LEN = 32;
  localparam int NPAIR   = VEC_LEN / 2;
  localparam int PW      = $clog2(NPAIR + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [PW-1:0] len_pairs = '0;
  logic          busy, done, err;
  logic [PW-1:0] rd_addr;
  logic [31:0]   rd_data1, rd_data2;
  logic [31:0]   tanh_din1, tanh_din2;
  logic          tanh_valid;
  logic          tanh_ready = 1'b1;
  logic          tanh_done;
  logic [31:0]   tanh_dout1, tanh_dout2;
  logic          res_wr_en;
  logic [PW-1:0] res_wr_addr;
  logic [31:0]   res_wr_data1, res_wr_data2;

  tanh_vector_sequencer #(.VEC_LEN(VEC_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len_pairs(len_pairs),
    .busy(busy), .done(done), .err(err),
    .rd_addr(rd_addr), .rd_data1(rd_data1), .rd_data2(rd_data2),
    .tanh_din1(tanh_din1), .tanh_din2(tanh_din2), .tanh_valid(tanh_valid),
    .tanh_ready(tanh_ready), .tanh_done(tanh_done),
    .tanh_dout1(tanh_dout1), .tanh_dout2(tanh_dout2),
    .res_wr_en(res_wr_en), .res_wr_addr(res_wr_addr),
    .res_wr_data1(res_wr_data1), .res_wr_data2(res_wr_data2)
  );

  always #5 clk = ~clk;

  // Source buffer: element pair p at rd_addr p.
  logic [31:0] mem [VEC_LEN];
  always_comb begin
    rd_data1 = mem[(2 * int'(rd_addr)) % VEC_LEN];
    rd_data2 = mem[(2 * int'(rd_addr) + 1) % VEC_LEN];
  end

  // Stand-in transfer function for the tanh unit; exact for +/-1.0.
  function automatic logic [31:0] tanh_ref(input logic [31:0] x);
    if (x == 32'h3F800000) return 32'h3F42F7D6;
    if (x == 32'hBF800000) return 32'hBF42F7D6;
    return {x[31], x[30:0] ^ 31'h15A5_C3E1};
  endfunction

  // Fixed-latency, in-order tanh unit model.
  typedef struct { int unsigned due; logic [31:0] a; logic [31:0] b; } pend_t;
  pend_t       pq[$];
  int unsigned cyc = 0;
  int unsigned lat = 41;
  logic        force_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pq.delete();
      tanh_done  <= 1'b0;
      tanh_dout1 <= '0;
      tanh_dout2 <= '0;
    end else begin
      if (tanh_valid && tanh_ready)
        pq.push_back('{cyc + lat, tanh_ref(tanh_din1), tanh_ref(tanh_din2)});
      if (pq.size() != 0 && pq[0].due <= cyc) begin
        tanh_done  <= 1'b1;
        tanh_dout1 <= pq[0].a;
        tanh_dout2 <= pq[0].b;
        void'(pq.pop_front());
      end else if (force_done) begin
        tanh_done  <= 1'b1;
        tanh_dout1 <= 32'h1234_5678;
        tanh_dout2 <= 32'h9ABC_DEF0;
      end else begin
        tanh_done <= 1'b0;
      end
    end
  end

  // Event recorder, sampled on the falling edge.
  typedef struct { int unsigned c; logic [PW-1:0] addr; logic [31:0] d1; logic [31:0] d2; } wr_t;
  wr_t         wr_log[$];
  int unsigned iss_log[$];
  int unsigned done_total = 0, done_cyc = 0, valid_total = 0, stab_bad = 0, busy_bad = 0;
  logic        stall_prev = 1'b0, done_prev = 1'b0;
  logic [31:0] hold1 = '0, hold2 = '0;

  always @(negedge clk) begin
    if (res_wr_en) wr_log.push_back('{cyc, res_wr_addr, res_wr_data1, res_wr_data2});
    if (tanh_valid && tanh_ready) iss_log.push_back(cyc);
    if (done) begin
      done_total <= done_total + 1;
      done_cyc   <= cyc;
    end
    if (tanh_valid) valid_total <= valid_total + 1;
    if (stall_prev && (!tanh_valid || {tanh_din1, tanh_din2} !== {hold1, hold2}))
      stab_bad <= stab_bad + 1;
    stall_prev <= tanh_valid && !tanh_ready;
    hold1      <= tanh_din1;
    hold2      <= tanh_din2;
    if ((done_prev && busy) || (done && !busy)) busy_bad <= busy_bad + 1;
    done_prev <= done;
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // mode 0: ready always high; mode 1: random ready plus one 5-cycle low stretch.
  task automatic run_vec(input int len, input int mode, input bit keep_mem,
                         input bit poke_start, input string tag);
    int          base_wr, base_done, base_iss, base_valid, base_stab, base_busy;
    int          n, lowleft;
    bit          did_low;
    int unsigned start_cyc;
    logic [95:0]  obs_w;
    logic [159:0] obs_r;
    if (!keep_mem)
      for (int i = 0; i < VEC_LEN; i++) mem[i] = $urandom;
    base_wr    = wr_log.size();
    base_iss   = iss_log.size();
    base_done  = done_total;
    base_valid = valid_total;
    base_stab  = stab_bad;
    base_busy  = busy_bad;
    start      = 1'b1;
    len_pairs  = PW'(len);
    start_cyc  = cyc;
    step();
    start = 1'b0;
    check({tag, " busy after start"}, busy, 1);
    n = 0; lowleft = 0; did_low = 0;
    while (done_total == base_done && n < 3000) begin
      if (mode == 1 && !did_low && tanh_valid && iss_log.size() >= base_iss + 3) begin
        lowleft = 5;
        did_low = 1;
      end
      if (lowleft > 0) begin
        tanh_ready = 1'b0;
        lowleft--;
      end else begin
        tanh_ready = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      if (poke_start && n == 6) begin
        start     = 1'b1;
        len_pairs = PW'(3);
      end else begin
        start = 1'b0;
      end
      step();
      n++;
    end
    tanh_ready = 1'b1;
    start      = 1'b0;
    check({tag, " done before timeout"}, done_total != base_done, 1);
    repeat (3) step();
    check({tag, " write count"}, wr_log.size() - base_wr, len);
    for (int p = 0; p < len; p++) begin
      obs_w = 'x;
      if (base_wr + p < wr_log.size())
        obs_w = {64'(wr_log[base_wr + p].addr), wr_log[base_wr + p].d1, wr_log[base_wr + p].d2};
      check($sformatf("%s write %0d", tag, p), obs_w,
            {64'(p), tanh_ref(mem[2 * p]), tanh_ref(mem[2 * p + 1])});
    end
    check({tag, " done pulses"}, done_total - base_done, 1);
    check({tag, " issued pairs"}, iss_log.size() - base_iss, len);
    check({tag, " din stable while stalled"}, stab_bad - base_stab, 0);
    check({tag, " busy around done"}, busy_bad - base_busy, 0);
    check({tag, " busy low after run"}, busy, 0);
    if (len == 0) begin
      check({tag, " done cycle"}, done_cyc, start_cyc + 1);
      check({tag, " no valid"}, valid_total - base_valid, 0);
    end else begin
      obs_r = 'x;
      if (wr_log.size() > base_wr) obs_r = 160'(wr_log[wr_log.size() - 1].c + 1);
      check({tag, " done one cycle after last write"}, 160'(done_cyc), obs_r);
    end
    if (mode == 0 && len > 1) begin
      obs_r = 'x;
      if (iss_log.size() >= base_iss + len)
        obs_r = 160'(iss_log[base_iss + len - 1] - iss_log[base_iss]);
      check({tag, " issue rate"}, obs_r, 160'(2 * (len - 1)));
      check({tag, " valid cycles"}, valid_total - base_valid, len);
    end
  endtask

  initial begin
    int base_wr, base_iss, base_done, n, len;
    logic [63:0] obs64;
    for (int i = 0; i < VEC_LEN; i++) mem[i] = '0;

    repeat (3) step();
    check("reset outputs",
          {busy, done, err, tanh_valid, res_wr_en, rd_addr, res_wr_addr,
           tanh_din1, tanh_din2, res_wr_data1, res_wr_data2}, '0);
    rst_n = 1'b1;
    step();
    check("idle after reset", {busy, done, err, tanh_valid, res_wr_en}, '0);

    // Single pair of +/-1.0 with the unit's nominal latency.
    mem[0] = 32'h3F800000;
    mem[1] = 32'hBF800000;
    lat    = 41;
    run_vec(1, 0, 1'b1, 1'b0, "one pair");
    obs64 = 'x;
    if (wr_log.size() > 0) obs64 = {wr_log[wr_log.size() - 1].d1, wr_log[wr_log.size() - 1].d2};
    check("one pair tanh values", obs64, {32'h3F42F7D6, 32'hBF42F7D6});

    lat = 5;
    run_vec(16, 0, 1'b0, 1'b0, "full vector");
    lat = 7;
    run_vec(16, 1, 1'b0, 1'b0, "ready stalls");
    run_vec(0, 0, 1'b0, 1'b0, "zero length");
    check("err clear before stray done", err, 0);

    // Stray result in IDLE, then a run with a start poked mid-way.
    base_wr    = wr_log.size();
    force_done = 1'b1;
    step();
    force_done = 1'b0;
    repeat (2) step();
    check("stray done sets err", err, 1);
    check("stray done no write", wr_log.size() - base_wr, 0);
    lat = 12;
    run_vec(6, 0, 1'b0, 1'b1, "start ignored");
    check("err sticky", err, 1);

    for (int r = 0; r < 4; r++) begin
      len = $urandom_range(1, NPAIR);
      lat = $urandom_range(2, 45);
      run_vec(len, int'($urandom_range(0, 1)), 1'b0, 1'b0, $sformatf("random %0d", r));
    end

    // Reset while draining.
    for (int i = 0; i < VEC_LEN; i++) mem[i] = $urandom;
    lat       = 30;
    base_iss  = iss_log.size();
    base_done = done_total;
    start     = 1'b1;
    len_pairs = PW'(4);
    step();
    start = 1'b0;
    n = 0;
    while (iss_log.size() < base_iss + 4 && n < 500) begin
      step();
      n++;
    end
    repeat (2) step();
    check("draining before reset", {busy, tanh_valid, done}, 3'b100);
    rst_n = 1'b0;
    #1;
    check("outputs zero in reset",
          {busy, done, err, tanh_valid, res_wr_en, rd_addr, res_wr_addr,
           tanh_din1, tanh_din2, res_wr_data1, res_wr_data2}, '0);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    check("no done from abandoned run", done_total - base_done, 0);
    lat = 9;
    run_vec(5, 0, 1'b0, 1'b0, "after reset");
    check("err cleared by reset", err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
